ab_seq_match_ctrl: RTL and testbench

Run controller around the team's two-input A-then-B sequence detector. Software or a parent block issues a start. The block then arms detection, counts completed A→B matches until a programmed target is reached, and aborts after a programmed cycle window. It reports busy, a per-match pulse, a done or timeout pulse, and a running match count.

---
 rtl/ab_seq_match_ctrl.sv | 105 ++++++++++
 tb/tb_ab_seq_match_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ab_seq_match_ctrl.sv
// Run controller for the A-then-B sequence detector.
// Counts matches up to a latched target, aborting after a cycle window.
module ab_seq_match_ctrl #(
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] target,
    input  logic [TMO_W-1:0] timeout_lim,
    input  logic             A,
    input  logic             B,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
    output logic             timed_out,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM_A = 3'd1,
        S_ARM_B = 3'd2,
        S_HIT   = 3'd3,
        S_DONE  = 3'd4,
        S_TMO   = 3'd5
    } st_t;

    st_t              cur, nxt;
    logic [CNT_W-1:0] tgt_q;
    logic [TMO_W-1:0] lim_q;
    logic [TMO_W-1:0] timer;
    logic [CNT_W-1:0] cnt_inc;
    logic             armed;
    logic             accept;
    logic             count_en;
    logic             final_hit;
    logic             tmo_hit;

    assign armed     = (cur == S_ARM_A) || (cur == S_ARM_B) || (cur == S_HIT);
    assign accept    = (cur == S_IDLE) && start;
    assign count_en  = (cur == S_ARM_B) && B;
    assign cnt_inc   = match_cnt + CNT_W'(1);
    assign final_hit = count_en && (cnt_inc == tgt_q);
    assign tmo_hit   = armed && (lim_q != '0)
                       && ((timer + TMO_W'(1)) == lim_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // A final match beats a simultaneous window expiry.
    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:  if (start) nxt = S_ARM_A;
            S_ARM_A: if (A) nxt = S_ARM_B;
            S_ARM_B: begin
                if (!B)             nxt = S_ARM_A;
                else if (final_hit) nxt = S_DONE;
                else                nxt = S_HIT;
            end
            S_HIT:   if (!(A && B)) nxt = S_ARM_A;
            S_DONE:  nxt = S_IDLE;
            S_TMO:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (tmo_hit && !final_hit) nxt = S_TMO;
    end

    always_comb begin
        busy      = armed;
        done      = (cur == S_DONE);
        timed_out = (cur == S_TMO);
        state     = cur;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_q     <= '0;
            lim_q     <= '0;
            timer     <= '0;
            match_cnt <= '0;
            match     <= 1'b0;
        end else begin
            match <= count_en;
            if (accept) begin
                tgt_q     <= (target == '0) ? CNT_W'(1) : target;
                lim_q     <= timeout_lim;
                timer     <= '0;
                match_cnt <= '0;
            end else begin
                if (armed)    timer     <= timer + TMO_W'(1);
                if (count_en) match_cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_ab_seq_match_ctrl.sv
// Directed self-checking bench for ab_seq_match_ctrl.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_ab_seq_match_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, A, B;
    logic [7:0]  target;
    logic [15:0] timeout_lim;
    logic        busy, match, done, timed_out;
    logic [7:0]  match_cnt;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    ab_seq_match_ctrl #(.CNT_W(8), .TMO_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .target(target),
        .timeout_lim(timeout_lim), .A(A), .B(B), .busy(busy),
        .match(match), .match_cnt(match_cnt), .done(done),
        .timed_out(timed_out), .state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; A = 0; B = 0;
        target = 0; timeout_lim = 0;
        step();
        rst = 0;
        checks++;
        if ({state, busy, match, done, timed_out, match_cnt} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state: got st=%0d busy=%b m=%b d=%b t=%b cnt=%0d want all 0",
                     state, busy, match, done, timed_out, match_cnt);
        end
        start = 1; target = 3; step();
        start = 0; A = 1; step();
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL reset_reach_armb: got %0d want 2", state);
        end
        A = 0; rst = 1; step();
        rst = 0;
        checks++;
        if ({state, busy, match, done, timed_out, match_cnt} !== 15'd0) begin
            errors++;
            $display("FAIL reset_midrun: got st=%0d busy=%b cnt=%0d want 0",
                     state, busy, match_cnt);
        end
    endtask

    task automatic test_basic();
        start = 1; target = 2; timeout_lim = 0; step();
        start = 0;
        checks++;
        if (state !== 3'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_arm: got st=%0d busy=%b want 1/1", state, busy);
        end
        A = 1; step();
        A = 0; B = 1; step();
        checks++;
        if (state !== 3'd3 || match !== 1'b1 || match_cnt !== 8'd1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_first: got st=%0d m=%b cnt=%0d d=%b want 3/1/1/0",
                     state, match, match_cnt, done);
        end
        B = 0; step();
        checks++;
        if (state !== 3'd1 || match !== 1'b0) begin
            errors++;
            $display("FAIL basic_rearm: got st=%0d m=%b want 1/0", state, match);
        end
        A = 1; step();
        A = 0; B = 1; step();
        B = 0;
        checks++;
        if (state !== 3'd4 || match !== 1'b1 || done !== 1'b1 || match_cnt !== 8'd2) begin
            errors++;
            $display("FAIL basic_done: got st=%0d m=%b d=%b cnt=%0d want 4/1/1/2",
                     state, match, done, match_cnt);
        end
        step();
        checks++;
        if (state !== 3'd0 || done !== 1'b0 || busy !== 1'b0 || match_cnt !== 8'd2) begin
            errors++;
            $display("FAIL basic_idle: got st=%0d d=%b busy=%b cnt=%0d want 0/0/0/2",
                     state, done, busy, match_cnt);
        end
    endtask

    task automatic test_hold();
        int pulses = 0;
        start = 1; target = 2; timeout_lim = 0; step();
        start = 0; A = 1; step();
        B = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (match === 1'b1) pulses++;
        end
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL hold_state: got %0d want 3", state);
        end
        A = 0; B = 0; step();
        checks++;
        if (state !== 3'd1 || match_cnt !== 8'd1 || pulses != 1) begin
            errors++;
            $display("FAIL hold_release: got st=%0d cnt=%0d pulses=%0d want 1/1/1",
                     state, match_cnt, pulses);
        end
        rst = 1; step(); rst = 0;
    endtask

    task automatic test_broken();
        start = 1; target = 1; timeout_lim = 0; step();
        start = 0; A = 1; step();
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL broken_armb: got %0d want 2", state);
        end
        A = 0; B = 0; step();
        checks++;
        if (state !== 3'd1 || match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL broken_back: got st=%0d cnt=%0d want 1/0", state, match_cnt);
        end
        A = 1; step();
        A = 0; B = 1; step();
        B = 0;
        checks++;
        if (state !== 3'd4 || done !== 1'b1 || match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL broken_done: got st=%0d d=%b cnt=%0d want 4/1/1",
                     state, done, match_cnt);
        end
        step();
    endtask

    task automatic test_timeout();
        int busy_cycles = 0;
        start = 1; target = 4; timeout_lim = 5; step();
        start = 0; A = 0; B = 0;
        if (busy === 1'b1) busy_cycles++;
        for (int i = 0; i < 4; i++) begin
            step();
            if (busy === 1'b1) busy_cycles++;
        end
        step();
        checks++;
        if (busy_cycles != 5 || state !== 3'd5 || timed_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire: got busy_cyc=%0d st=%0d t=%b busy=%b want 5/5/1/0",
                     busy_cycles, state, timed_out, busy);
        end
        step();
        checks++;
        if (state !== 3'd0 || timed_out !== 1'b0 || match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL timeout_idle: got st=%0d t=%b cnt=%0d want 0/0/0",
                     state, timed_out, match_cnt);
        end
    endtask

    task automatic test_tie_and_start();
        start = 1; target = 1; timeout_lim = 3; step();
        start = 0; A = 0; step();
        A = 1; step();
        A = 0; B = 1; step();
        B = 0;
        checks++;
        if (state !== 3'd4 || done !== 1'b1 || timed_out !== 1'b0
            || match !== 1'b1 || match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL tie_done: got st=%0d d=%b t=%b m=%b cnt=%0d want 4/1/0/1/1",
                     state, done, timed_out, match, match_cnt);
        end
        start = 1; step();
        checks++;
        if (state !== 3'd0 || timed_out !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: got st=%0d t=%b want 0/0", state, timed_out);
        end
        step();
        start = 0;
        checks++;
        if (state !== 3'd1 || match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL start_in_idle: got st=%0d cnt=%0d want 1/0", state, match_cnt);
        end
        rst = 1; step(); rst = 0;
    endtask

    initial begin
        rst = 1; start = 0; A = 0; B = 0; target = 0; timeout_lim = 0;
        test_reset();
        test_basic();
        test_hold();
        test_broken();
        test_timeout();
        test_tie_and_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
